// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment driver showing a captured 32-bit instruction word in hex.
// Optional leading-zero blanking; the digit-0 decimal point flags a recently changed word.
module seg_scan_driver #(
  parameter int unsigned PRESCALE      = 50000,
  parameter int unsigned BLANK_LEADING = 1,
  parameter int unsigned NEW_FRAMES    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        load,
  input  logic        freeze,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        dp,
  output logic [31:0] shown
);

  localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int unsigned NW = (NEW_FRAMES > 0) ? $clog2(NEW_FRAMES + 1) : 1;
  localparam logic [PW-1:0] PresLast = PW'(PRESCALE - 1);
  localparam logic [NW-1:0] NewLoad  = NW'(NEW_FRAMES);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [NW-1:0] new_cnt_q, new_cnt_d;
  logic [31:0]   shown_q, shown_d;
  logic [6:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;
  logic          dp_q, dp_d;

  logic          capture, changed, slot_end, frame_wrap;
  logic [7:0]    nib_nz;
  logic [3:0]    nibble;
  logic          blank;

  assign capture    = load & ~freeze;
  assign changed    = capture && (instr != shown_q);
  assign slot_end   = (presc_q == PresLast);
  assign frame_wrap = slot_end && (idx_q == 3'd7);

  always_comb begin
    presc_d   = slot_end ? '0 : presc_q + 1'b1;
    idx_d     = slot_end ? idx_q + 3'd1 : idx_q;
    shown_d   = capture ? instr : shown_q;
    new_cnt_d = new_cnt_q;
    // A fresh word reloads the counter even if a frame ends in the same cycle.
    if (changed) begin
      new_cnt_d = NewLoad;
    end else if (frame_wrap && (new_cnt_q != '0)) begin
      new_cnt_d = new_cnt_q - 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      nib_nz[i] = |shown_q[4*i +: 4];
    end
    nibble = shown_q[{idx_q, 2'b00} +: 4];
    // Digit idx is a leading zero when it and every higher nibble are zero.
    blank  = (BLANK_LEADING != 0) && (idx_q != 3'd0) && ((nib_nz >> idx_q) == 8'd0);
    case (nibble)
      4'h0:    seg_d = 7'b1000000;
      4'h1:    seg_d = 7'b1111001;
      4'h2:    seg_d = 7'b0100100;
      4'h3:    seg_d = 7'b0110000;
      4'h4:    seg_d = 7'b0011001;
      4'h5:    seg_d = 7'b0010010;
      4'h6:    seg_d = 7'b0000010;
      4'h7:    seg_d = 7'b1111000;
      4'h8:    seg_d = 7'b0000000;
      4'h9:    seg_d = 7'b0011000;
      4'hA:    seg_d = 7'b0001000;
      4'hB:    seg_d = 7'b0000011;
      4'hC:    seg_d = 7'b1000110;
      4'hD:    seg_d = 7'b0100001;
      4'hE:    seg_d = 7'b0000110;
      default: seg_d = 7'b0001110;
    endcase
    if (blank) begin
      seg_d = 7'b1111111;
    end
    an_d = ~(8'b1 << idx_q);
    dp_d = ~((idx_q == 3'd0) && (new_cnt_q != '0));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q   <= '0;
      idx_q     <= '0;
      new_cnt_q <= '0;
      shown_q   <= '0;
      seg_q     <= 7'b1111111;
      an_q      <= 8'hFF;
      dp_q      <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      new_cnt_q <= new_cnt_d;
      shown_q   <= shown_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign dp    = dp_q;
  assign shown = shown_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (PRESCALE=4, NEW_FRAMES=2) with a per-cycle output scoreboard.
module tb_seg_scan_driver;

  logic        clock = 1'b0;
  logic        reset, load, freeze;
  logic [31:0] instr;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        dp;
  logic [31:0] shown;

  seg_scan_driver #(
    .PRESCALE     (4),
    .BLANK_LEADING(1),
    .NEW_FRAMES   (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .instr (instr),
    .load  (load),
    .freeze(freeze),
    .seg   (seg),
    .an    (an),
    .dp    (dp),
    .shown (shown)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        dp;
    logic [31:0] shown;
  } out_t;

  out_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference state of the display
  logic [31:0] m_shown;
  int          m_presc, m_idx, m_new;

  logic [6:0]  obs_seg;
  logic [7:0]  obs_an;
  logic        obs_dp;
  logic [31:0] obs_shown;

  logic [6:0] hex_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [6:0] seen [8];
  logic [7:0] an_seq [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [6:0] req30 [8] = '{7'b0001000, 7'b1000000, 7'b1000000, 7'b1000000,
                            7'b0100100, 7'b1000000, 7'b1000000, 7'b0100100};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] model_seg();
    logic [31:0] upper;
    upper = m_shown >> (4 * m_idx);
    if (m_idx != 0 && upper == 32'h0) return 7'b1111111;
    return hex_tbl[upper[3:0]];
  endfunction

  task automatic step(input bit rst, input bit ld, input bit frz, input logic [31:0] ins);
    out_t e;
    out_t got;
    bit   slot_end;
    if (rst) begin
      e = '{seg: 7'h7F, an: 8'hFF, dp: 1'b1, shown: 32'h0};
      m_shown = 32'h0; m_presc = 0; m_idx = 0; m_new = 0;
    end else begin
      e.seg   = model_seg();
      e.an    = ~(8'h01 << m_idx);
      e.dp    = !(m_idx == 0 && m_new != 0);
      e.shown = (ld && !frz) ? ins : m_shown;
      slot_end = (m_presc == 3);
      if (ld && !frz && ins != m_shown) m_new = 2;
      else if (slot_end && m_idx == 7 && m_new > 0) m_new = m_new - 1;
      if (ld && !frz) m_shown = ins;
      m_presc = slot_end ? 0 : m_presc + 1;
      if (slot_end) m_idx = (m_idx + 1) % 8;
    end
    exp_q.push_back(e);
    reset = rst; load = ld; freeze = frz; instr = ins;
    @(posedge clock);
    #1;
    obs_seg = seg; obs_an = an; obs_dp = dp; obs_shown = shown;
    got = '{seg: seg, an: an, dp: dp, shown: shown};
    e = exp_q.pop_front();
    check("scoreboard", 64'(got), 64'(e));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic wait_slot(input int idx, input int presc, input int need_new);
    bit found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_idx == idx && m_presc == presc && (need_new < 0 || m_new == need_new)) found = 1'b1;
      else idle();
    end
    check("align_timeout", 64'(found), 64'd1);
  endtask

  // Counts digit-0 slots in which dp was lit over nframes frames.
  task automatic count_dp_frames(input int nframes, output int frames);
    bit in_slot = 1'b0;
    bit lit = 1'b0;
    frames = 0;
    for (int i = 0; i < nframes * 32; i++) begin
      idle();
      if (obs_an == 8'hFE) begin
        if (!in_slot) begin in_slot = 1'b1; lit = 1'b0; end
        if (obs_dp == 1'b0) lit = 1'b1;
      end else if (in_slot) begin
        in_slot = 1'b0;
        frames += int'(lit);
      end
    end
    if (in_slot) frames += int'(lit);
  endtask

  task automatic scan_digits();
    for (int j = 0; j < 8; j++) seen[j] = 'x;
    for (int i = 0; i < 32; i++) begin
      idle();
      for (int j = 0; j < 8; j++) if (obs_an == ~(8'h01 << j)) seen[j] = obs_seg;
    end
  endtask

  initial begin
    int frames;
    reset = 1'b1; load = 1'b0; freeze = 1'b0; instr = 32'h0;
    m_shown = 32'h0; m_presc = 0; m_idx = 0; m_new = 0;

    step(1'b1, 1'b1, 1'b0, 32'h1234_5678);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("reset_seg", 64'(obs_seg), 64'h7F);
    check("reset_an", 64'(obs_an), 64'hFF);
    check("reset_dp", 64'(obs_dp), 64'd1);
    check("reset_shown", 64'(obs_shown), 64'h0);

    // Idle scan: 4 cycles per digit, only digit 0 lit
    for (int k = 0; k < 40; k++) begin
      idle();
      check("idle_an", 64'(obs_an), 64'(an_seq[(k / 4) % 8]));
      check("idle_seg", 64'(obs_seg), (obs_an == 8'hFE) ? 64'h40 : 64'h7F);
    end

    wait_slot(0, 0, -1);
    step(1'b0, 1'b1, 1'b0, 32'h2002_000A);
    check("load_shown", 64'(obs_shown), 64'h2002_000A);
    count_dp_frames(5, frames);
    check("dp_frames_new", 64'(frames), 64'd2);
    scan_digits();
    for (int j = 0; j < 8; j++) check("digits_2002000A", 64'(seen[j]), 64'(req30[j]));

    wait_slot(0, 0, -1);
    step(1'b0, 1'b1, 1'b0, 32'h2002_000A);
    count_dp_frames(4, frames);
    check("dp_frames_same", 64'(frames), 64'd0);

    wait_slot(0, 0, -1);
    step(1'b0, 1'b1, 1'b0, 32'h2002_000B);
    count_dp_frames(5, frames);
    check("dp_frames_relight", 64'(frames), 64'd2);

    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    check("freeze_shown", 64'(obs_shown), 64'h2002_000B);
    idle();
    step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    check("unfrozen_shown", 64'(obs_shown), 64'hFFFF_FFFF);
    scan_digits();
    for (int j = 0; j < 8; j++) check("digits_F", 64'(seen[j]), 64'h0E);

    // Capture on the frame-wrap cycle while the counter sits at 1
    wait_slot(7, 3, 1);
    step(1'b0, 1'b1, 1'b0, 32'h1234_5678);
    count_dp_frames(5, frames);
    check("dp_frames_load_wins", 64'(frames), 64'd2);

    wait_slot(5, 1, -1);
    step(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    check("midscan_reset_seg", 64'(obs_seg), 64'h7F);
    check("midscan_reset_an", 64'(obs_an), 64'hFF);
    check("midscan_reset_dp", 64'(obs_dp), 64'd1);
    check("midscan_reset_shown", 64'(obs_shown), 64'h0);
    idle();
    check("release_an", 64'(obs_an), 64'hFE);
    check("release_seg", 64'(obs_seg), 64'h40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter PRESCALE, default 50000, sets clock cycles per digit slot and shall be at least 2.
REQ-002 Parameter BLANK_LEADING, default 1, enables leading-zero blanking when 1.
REQ-003 Parameter NEW_FRAMES, default 4, sets the number of full 8-digit scan frames the change indicator stays lit.
REQ-004 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port instr, input, 32 bits: instruction word from the pipeline IF/ID output.
REQ-007 Port load, input, 1 bit: capture strobe for instr.
REQ-008 Port freeze, input, 1 bit: when high, blocks capture.
REQ-009 Port seg, output, 7 bits: active-low segments {g,f,e,d,c,b,a}, registered.
REQ-010 Port an, output, 8 bits: active-low one-hot digit enable, registered.
REQ-011 Port dp, output, 1 bit: active-low decimal point, registered.
REQ-012 Port shown, output, 32 bits: currently captured word, registered.

Function
REQ-013 Capture: when load=1 and freeze=0 at a rising edge, shown shall equal instr after that edge; otherwise shown holds.
REQ-014 Change detect: a capture whose instr differs from the current shown value shall load the new-counter with NEW_FRAMES; an equal-value capture shall leave the new-counter unchanged.
REQ-015 Prescaler: counts 0..PRESCALE-1 and wraps to 0; digit index idx (3 bits) increments only on the cycle the prescaler is at PRESCALE-1.
REQ-016 idx wraps 7->0; each 7->0 wrap ends a frame and decrements a nonzero new-counter by 1; the new-counter saturates at 0.
REQ-017 If a capture that loads the new-counter and a frame wrap occur in the same cycle, the load shall win.
REQ-018 Digit i displays shown[4i+3:4i]; digit 0 is the least-significant nibble.
REQ-019 Hex decode, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.
REQ-020 Blanking: when BLANK_LEADING=1, digit i (i>=1) is blanked (seg=1111111) if nibbles i..7 of shown are all zero; digit 0 is never blanked.
REQ-021 an shall be ~(1<<idx) and dp shall be 0 only when idx=0 and the new-counter is nonzero, else 1.
REQ-022 Latency: seg, an and dp shall be registered and reflect the idx, shown and new-counter values of the preceding cycle (1-cycle latency).
REQ-023 A capture mid-slot shall take effect on seg one cycle after shown changes, without restarting the prescaler or idx.
REQ-024 freeze shall affect capture only; scanning and new-counter decrement shall continue.

Reset
REQ-025 While reset=1 at a rising edge: shown=0, prescaler=0, idx=0, new-counter=0, seg=1111111, an=11111111, dp=1.
REQ-026 reset shall override load; a capture requested in a reset cycle shall be discarded.
REQ-027 On the first edge after reset deasserts: an=11111110 and seg=1000000 (digit 0 showing "0").
REQ-028 Reset asserted mid-scan shall return all state to the REQ-025 values on the next edge.

Verification (PRESCALE=4, NEW_FRAMES=2)
REQ-029 Reset, then idle 40 cycles -> an steps FE,FD,FB,...,7F, 4 cycles each, then wraps to FE; seg=1000000 on digit 0 and 1111111 on all other digits.
REQ-030 load=1 with instr=0x2002000A -> shown=0x2002000A; digit0=0001000 (A), digits 1-3=1000000, digit4=0100100 (2), digit5=1000000 (not blanked), digit6=1000000 (not blanked), digit7=0100100 (2).
REQ-031 After the REQ-030 capture -> dp=0 during digit-0 slots for exactly 2 frames, then stays 1; reloading 0x2002000A does not relight dp; loading 0x2002000B relights it.
REQ-032 freeze=1, load=1, instr=0xFFFFFFFF -> shown unchanged and scan continues; freeze=0 then load -> all digits show 0001110 (F).
REQ-033 Assert reset during the digit-5 slot with load=1 -> next edge: all outputs at their REQ-025 reset values and shown=0.
REQ-034 Capture timed on the same cycle as the 7->0 wrap with new-counter=1 -> new-counter=2 (load wins).
